// File: rtl/pwm_compare16.sv
// pwm_compare16 -- 16-bit PWM / output-compare unit fed by the timer peripheral.
//
// Consumes the timer's live count and wrap pulse. Produces a registered PWM
// waveform, a sticky compare-match flag and a level interrupt. Duty updates
// are double-buffered (shadow -> active) so the waveform never glitches mid-period.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   data[63:0]   shared bus; driven only during local reads, else high-Z
//   address[3:0] local register offset (pre-decoded)
//   chip_select  block selected
//   mem_read     bus read strobe
//   mem_write    bus write strobe
//   count_in     timer count value
//   period_in    timer period value (informational; compare uses count only)
//   timer_wrap   one-cycle pulse when the timer count returns to 0
//   pwm_out      registered PWM output
//   irq          interrupt request (MATCH & IRQEN), level
//
// Register map: 0 PWMCON {IRQEN,MATCH,ONESHOT,POL,EN}, 1 DUTY (shadow),
//               2 DUTY_ACT (RO), 3 STATUS {state[1:0],PEND}, 4-F read 0.
module pwm_compare16 #(
  parameter logic [15:0] DUTY_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  inout  logic [63:0] data,
  input  logic [3:0]  address,
  input  logic        chip_select,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] count_in,
  input  logic [15:0] period_in,
  input  logic        timer_wrap,
  output logic        pwm_out,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        en;
  logic        pol;
  logic        oneshot;
  logic        match;
  logic        irqen;
  logic [15:0] duty;
  logic [15:0] duty_act;
  logic        pend;

  logic        wr;
  logic        rd;
  logic        wr_con;
  logic        wr_duty;
  logic        raw;
  logic        idle_load;
  logic        wrap_evt;
  logic        en_hw_clr;
  logic        match_set;
  logic [63:0] rdata;

  // Only the low 16 bits of the bus and none of the period are consumed.
  logic        unused_in;
  assign unused_in = ^{data[63:16], period_in};

  assign wr      = chip_select & mem_write & ~mem_read;
  assign rd      = chip_select & mem_read & ~mem_write;
  assign wr_con  = wr & (address == 4'h0);
  assign wr_duty = wr & (address == 4'h1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, raw waveform and transfer/clear strobes
  always_comb begin
    state_next = state;
    raw        = 1'b0;
    idle_load  = 1'b0;
    wrap_evt   = 1'b0;
    en_hw_clr  = 1'b0;
    match_set  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          idle_load  = 1'b1;
        end
      end
      RUN: begin
        raw       = (count_in < duty_act);
        match_set = (count_in == duty_act);
        wrap_evt  = timer_wrap;
        if (!en) begin
          state_next = IDLE;
        end else if (timer_wrap && oneshot) begin
          state_next = DONE;
          en_hw_clr  = 1'b1;
        end
      end
      DONE: begin
        // EN was cleared on entry; a software EN=1 restarts via IDLE.
        if (en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control/duty registers and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      pol      <= 1'b0;
      oneshot  <= 1'b0;
      match    <= 1'b0;
      irqen    <= 1'b0;
      duty     <= DUTY_RESET;
      duty_act <= DUTY_RESET;
      pend     <= 1'b0;
      pwm_out  <= 1'b0;
    end else begin
      // A software PWMCON write takes priority over the one-shot EN clear.
      if (wr_con) begin
        en      <= data[0];
        pol     <= data[1];
        oneshot <= data[2];
        irqen   <= data[4];
      end else if (en_hw_clr) begin
        en <= 1'b0;
      end

      // Hardware set beats a software clear in the same cycle; writing 1 does nothing.
      match <= match_set | (match & ~(wr_con & ~data[3]));

      // A DUTY write coinciding with a transfer goes straight into both
      // registers, leaving nothing pending.
      if (wr_duty) begin
        duty <= data[15:0];
        if (idle_load || wrap_evt) begin
          duty_act <= data[15:0];
          pend     <= 1'b0;
        end else begin
          pend <= 1'b1;
        end
      end else if (idle_load || (wrap_evt && pend)) begin
        duty_act <= duty;
        pend     <= 1'b0;
      end else if (wrap_evt) begin
        pend <= 1'b0;
      end

      pwm_out <= raw ^ pol;
    end
  end

  assign irq = match & irqen;

  // Read mux
  always_comb begin
    rdata = '0;
    case (address)
      4'h0: rdata[7:0]  = {3'b000, irqen, match, oneshot, pol, en};
      4'h1: rdata[15:0] = duty;
      4'h2: rdata[15:0] = duty_act;
      4'h3: rdata[2:0]  = {state, pend};
      default: rdata = '0;
    endcase
  end

  assign data = rd ? rdata : 'z;

endmodule

// File: tb/tb_pwm_compare16.sv
// Directed testbench for pwm_compare16 with hand-computed expectations.
module tb_pwm_compare16;

  logic        clk;
  logic        rst;
  tri1 [63:0]  data;
  logic [3:0]  address;
  logic        chip_select;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] count_in;
  logic [15:0] period_in;
  logic        timer_wrap;
  logic        pwm_out;
  logic        irq;

  logic [63:0] bus_drv;
  logic        bus_en;
  assign data = bus_en ? bus_drv : 'z;

  int n_cmp;
  int n_err;

  pwm_compare16 #(.DUTY_RESET(16'h0005)) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .address     (address),
    .chip_select (chip_select),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .count_in    (count_in),
    .period_in   (period_in),
    .timer_wrap  (timer_wrap),
    .pwm_out     (pwm_out),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [15:0] c, input logic w);
    count_in   = c;
    timer_wrap = w;
    tick();
    timer_wrap = 1'b0;
  endtask

  task automatic set_wr(input logic [3:0] a, input logic [63:0] v);
    address     = a;
    chip_select = 1'b1;
    mem_write   = 1'b1;
    mem_read    = 1'b0;
    bus_drv     = v;
    bus_en      = 1'b1;
  endtask

  task automatic clr_bus();
    chip_select = 1'b0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    bus_en      = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a, input logic [63:0] exp);
    logic [63:0] v;
    bus_en      = 1'b0;
    address     = a;
    chip_select = 1'b1;
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    #1;
    v = data;
    chip_select = 1'b0;
    mem_read    = 1'b0;
    chk(tag, v, exp);
  endtask

  initial begin
    logic [9:0] wave4;
    wave4 = 10'b00_0000_1111;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    address = '0;
    chip_select = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    count_in = '0;
    period_in = 16'd9;
    timer_wrap = 1'b0;
    bus_drv = '0;
    bus_en = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_pwm", {63'b0, pwm_out}, 64'd0);
    chk("rst_irq", {63'b0, irq}, 64'd0);
    chk_rd("rst_con", 4'h0, 64'h0);
    chk_rd("rst_duty", 4'h1, 64'h5);
    chk_rd("rst_act", 4'h2, 64'h5);
    chk_rd("rst_stat", 4'h3, 64'h0);
    #1;
    chk("rst_hiz", data, 64'hFFFF_FFFF_FFFF_FFFF);
    rst = 1'b0;
    tick();

    // Basic PWM, DUTY=4
    set_wr(4'h1, 64'h4); cyc(0, 0); clr_bus();
    chk_rd("shadow_wr", 4'h1, 64'h4);
    chk_rd("act_hold", 4'h2, 64'h5);
    chk_rd("pend_idle", 4'h3, 64'h1);
    set_wr(4'h0, 64'h01); cyc(0, 0); clr_bus();
    cyc(0, 0);
    chk_rd("run_stat", 4'h3, 64'h2);
    chk_rd("run_act", 4'h2, 64'h4);
    for (int k = 0; k < 10; k++) begin
      cyc(16'(k), 0);
      chk($sformatf("basic_pwm_c%0d", k), {63'b0, pwm_out}, {63'b0, wave4[k]});
      if (k == 3) chk_rd("match_pre", 4'h0, 64'h01);
      if (k == 4) chk_rd("match_set", 4'h0, 64'h09);
    end
    chk("irq_disabled", {63'b0, irq}, 64'd0);
    cyc(0, 1);
    chk("wrap_pwm", {63'b0, pwm_out}, 64'd1);

    // Double buffer
    cyc(1, 0);
    set_wr(4'h1, 64'h7); cyc(2, 0); clr_bus();
    chk_rd("db_shadow", 4'h1, 64'h7);
    chk_rd("db_act_hold", 4'h2, 64'h4);
    chk_rd("db_pend", 4'h3, 64'h3);
    cyc(3, 0); cyc(4, 0); cyc(5, 0);
    chk("db_old_duty", {63'b0, pwm_out}, 64'd0);
    for (int k = 6; k < 10; k++) cyc(16'(k), 0);
    cyc(0, 1);
    chk_rd("db_xfer_act", 4'h2, 64'h7);
    chk_rd("db_xfer_stat", 4'h3, 64'h2);
    cyc(5, 0);
    chk("db_new_duty", {63'b0, pwm_out}, 64'd1);
    for (int k = 6; k < 10; k++) cyc(16'(k), 0);
    set_wr(4'h1, 64'h3); cyc(0, 1); clr_bus();
    chk_rd("same_wrap_act", 4'h2, 64'h3);
    chk_rd("same_wrap_stat", 4'h3, 64'h2);

    // DUTY=0: constant low
    set_wr(4'h1, 64'h0);
    for (int k = 1; k < 10; k++) cyc(16'(k), 0);
    clr_bus();
    for (int k = 1; k < 10; k++) begin
      if (k == 9) set_wr(4'h1, 64'h0);
      cyc(16'(k), 0);
    end
    clr_bus();
    cyc(0, 1);
    chk_rd("duty0_act", 4'h2, 64'h0);
    for (int k = 1; k < 10; k++) begin
      cyc(16'(k), 0);
      chk($sformatf("duty0_c%0d", k), {63'b0, pwm_out}, 64'd0);
    end

    // DUTY=FFFF with period 9: constant high
    set_wr(4'h1, 64'hFFFF); cyc(0, 1); clr_bus();
    chk("dffff_first", {63'b0, pwm_out}, 64'd0);
    for (int k = 1; k < 10; k++) begin
      cyc(16'(k), 0);
      chk($sformatf("dffff_c%0d", k), {63'b0, pwm_out}, 64'd1);
    end

    // POL=1 inverts both waveforms
    set_wr(4'h0, 64'h03); cyc(0, 1); clr_bus();
    for (int k = 1; k < 10; k++) begin
      cyc(16'(k), 0);
      chk($sformatf("pol_ffff_c%0d", k), {63'b0, pwm_out}, 64'd0);
    end
    set_wr(4'h1, 64'h0); cyc(0, 1); clr_bus();
    for (int k = 1; k < 10; k++) begin
      cyc(16'(k), 0);
      chk($sformatf("pol_zero_c%0d", k), {63'b0, pwm_out}, 64'd1);
    end
    set_wr(4'h0, 64'h02); cyc(0, 1); clr_bus();
    cyc(1, 0);
    cyc(2, 0);
    chk("pol_idle", {63'b0, pwm_out}, 64'd1);
    chk_rd("pol_idle_stat", 4'h3, 64'h0);

    // One-shot
    set_wr(4'h1, 64'h4); cyc(0, 0); clr_bus();
    set_wr(4'h0, 64'h05); cyc(0, 0); clr_bus();
    cyc(0, 0);
    chk_rd("os_run", 4'h3, 64'h2);
    for (int k = 0; k < 10; k++) cyc(16'(k), 0);
    cyc(0, 1);
    cyc(1, 0);
    chk("os_done_pwm", {63'b0, pwm_out}, 64'd0);
    chk_rd("os_done_stat", 4'h3, 64'h4);
    chk_rd("os_en_clr", 4'h0, 64'h0C);
    set_wr(4'h0, 64'h05); cyc(2, 0); clr_bus();
    chk_rd("os_wr_en_stat", 4'h3, 64'h4);
    cyc(3, 0);
    chk_rd("os_to_idle", 4'h3, 64'h0);
    cyc(4, 0);
    chk_rd("os_to_run", 4'h3, 64'h2);
    for (int k = 5; k < 10; k++) cyc(16'(k), 0);
    set_wr(4'h0, 64'h05); cyc(0, 1); clr_bus();
    chk_rd("os_sw_wins_con", 4'h0, 64'h05);
    chk_rd("os_sw_wins_stat", 4'h3, 64'h4);

    // IRQ / MATCH race
    set_wr(4'h0, 64'h11); cyc(1, 0); clr_bus();
    cyc(2, 0);
    chk_rd("irq_run", 4'h3, 64'h2);
    cyc(3, 0);
    set_wr(4'h0, 64'h11); cyc(4, 0); clr_bus();
    chk("race_irq", {63'b0, irq}, 64'd1);
    chk_rd("race_con", 4'h0, 64'h19);
    set_wr(4'h0, 64'h11); cyc(5, 0); clr_bus();
    chk("clr_irq", {63'b0, irq}, 64'd0);
    chk_rd("clr_con", 4'h0, 64'h11);
    set_wr(4'h0, 64'h19); cyc(6, 0); clr_bus();
    chk("set1_ignored_irq", {63'b0, irq}, 64'd0);
    chk_rd("set1_ignored_con", 4'h0, 64'h11);

    // Asynchronous reset mid-RUN with pwm_out high and POL=1
    cyc(7, 0); cyc(8, 0); cyc(9, 0);
    set_wr(4'h0, 64'h13); cyc(0, 1); clr_bus();
    cyc(5, 0);
    chk("pre_rst_pwm", {63'b0, pwm_out}, 64'd1);
    set_wr(4'h1, 64'h9); cyc(6, 0); clr_bus();
    chk_rd("pre_rst_stat", 4'h3, 64'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pwm", {63'b0, pwm_out}, 64'd0);
    chk("async_rst_irq", {63'b0, irq}, 64'd0);
    chk_rd("arst_con", 4'h0, 64'h0);
    chk_rd("arst_duty", 4'h1, 64'h5);
    chk_rd("arst_act", 4'h2, 64'h5);
    chk_rd("arst_stat", 4'h3, 64'h0);
    #1;
    chk("arst_hiz", data, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rst = 1'b0;
    tick();

    // Unmapped offsets
    set_wr(4'h4, 64'hFFFF_FFFF_FFFF_FFFF); cyc(0, 0); clr_bus();
    set_wr(4'hF, 64'hFFFF_FFFF_FFFF_FFFF); cyc(0, 0); clr_bus();
    chk_rd("unmapped_4", 4'h4, 64'h0);
    chk_rd("unmapped_f", 4'hF, 64'h0);
    chk_rd("unmapped_con", 4'h0, 64'h0);
    chk_rd("unmapped_duty", 4'h1, 64'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
